i2c_slave_read_word: RTL and testbench
======================================

# i2c_slave_read_word

Parametrised I2C slave receive engine: after a one-cycle `read_en` request it captures `DATA_WIDTH` consecutive SDA bits, one per SCL high phase, and returns them as a word with a one-cycle `read_finish` pulse. It replaces repeated per-bit read requests from the slave control FSM with a single word-level request. It flags any SDA transition while SCL is high (START/STOP condition on the bus) as an error, aborts, and reports which kind.

## Interface
- `DATA_WIDTH`, 8 — bits per word; legal range 2..32.
- `MSB_FIRST`, 1 — 1: first received bit lands in `read_data_o[DATA_WIDTH-1]`; 0: first bit lands in `read_data_o[0]`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `read_en`  in  1  single-cycle request to receive one word; ignored unless idle.
- `scl_i`  in  1  SCL level, already synchronised to `clk` upstream.
- `sda_i`  in  1  SDA level, already synchronised to `clk` upstream.
- `read_data_o`  out  DATA_WIDTH  last completed word; changes only with `read_finish`.
- `read_finish`  out  1  one-cycle pulse: word complete, `read_data_o` valid the same cycle.
- `read_err`  out  1  one-cycle pulse: SDA changed during SCL high; word discarded.
- `read_err_type`  out  1  valid with `read_err`: 0 = SDA fell (START), 1 = SDA rose (STOP); holds its value otherwise.
- `read_err_bit`  out  $clog2(DATA_WIDTH+1)  index (0-based, in receive order) of the bit being received when the error occurred; valid with `read_err`.
- `busy`  out  1  high from the cycle after an accepted `read_en` until the `read_finish` or `read_err` cycle, inclusive.

## Operation
- States: IDLE, WAIT_HIGH, HIGH, DONE, ERR.
- IDLE: on `read_en`, clear the bit counter and move to WAIT_HIGH. Nothing is sampled in IDLE.
- WAIT_HIGH: when `scl_i`=1, capture `sda_i` as the reference bit, shift it into the internal shift register, and move to HIGH.
- HIGH, `scl_i`=1, `sda_i` != reference bit: move to ERR. Record the error type and the counter value.
- HIGH, `scl_i`=0 (falling edge):
  - if counter = DATA_WIDTH-1, move to DONE;
  - else increment the counter and move to WAIT_HIGH.
- DONE: one cycle. Pulse `read_finish`, load `read_data_o` from the shift register, return to IDLE.
- ERR: one cycle. Pulse `read_err`, return to IDLE. `read_data_o` is not updated.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - Either way, after DATA_WIDTH bits the first bit received is at the documented position.
- If `read_en` arrives while SCL is already high, that high phase counts as bit 0. The bit is sampled in the first WAIT_HIGH cycle, which still falls inside the high phase.
- `read_en` outside IDLE is ignored (no queueing). This includes the DONE and ERR cycles.
- There is no timeout: a stalled SCL holds the block in WAIT_HIGH or HIGH indefinitely.

## Timing
- Reset values: `read_data_o`=0, `read_finish`=0, `read_err`=0, `read_err_type`=0, `read_err_bit`=0, `busy`=0. State resets to IDLE, counter and shift register to 0.
- Reset asserted mid-word: immediate return to IDLE. No finish or error pulse is issued, and the partial word is lost.
- `read_en` at cycle t → WAIT_HIGH at t+1. The earliest sample is at t+1.
- The last falling edge seen in HIGH at cycle f → DONE at f+1, so `read_finish` is high at cycle f+1.
- SDA change seen at cycle e → `read_err` is high at cycle e+1.
- If SDA changes in the same cycle SCL falls, `scl_i`=0 takes priority: the bit is treated as complete, not as an error.
- Back-to-back words: `read_en` may be re-issued in the cycle after `read_finish`.
- Worst-case throughput: one word per DATA_WIDTH SCL periods plus 2 clk.

## Structure
- Shared `i2c_pkg`:
  - state encoding constants;
  - error type constants (`ERR_START`=0, `ERR_STOP`=1).
- Single module, no sub-module. Edge handling is done by the level checks in WAIT_HIGH and HIGH, so no separate edge detector is needed.
- Expected size: about 150–250 lines of RTL.

## Test plan
- SCL = clk/8; `read_en` issued 1 clk after each SCL rise; words 0x13, 0x57, 0x9B, 0xDF, MSB_FIRST=1 → four `read_finish` pulses, `read_data_o` matching each word, `read_err` never asserted.
- Same stream with MSB_FIRST=0 and DATA_WIDTH=8 → `read_data_o` = bit-reversed words (0xC8, 0xEA, 0xD9, 0xFB).
- DATA_WIDTH=16, stream 0x1357 → exactly one `read_finish`, after the 16th SCL fall, with `read_data_o`=0x1357.
- During the SCL high of bit 3, SDA goes 1→0 → `read_err`=1, `read_err_type`=0, `read_err_bit`=3, no `read_finish`, `read_data_o` unchanged. Repeat with 0→1 → `read_err_type`=1.
- `rst_n` pulsed low after bit 5 → all outputs return to 0. A new `read_en` after release receives a full, correct word.
- `read_en` pulsed while `busy`=1 → ignored: only one `read_finish` for that word.

Source files
------------

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared I2C slave state encoding and error type constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HIGH = 3'd1,
    S_HIGH      = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam logic ERR_START = 1'b0;
  localparam logic ERR_STOP  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_read_word.sv
// ============================================================================
// Module   : i2c_slave_read_word
// Purpose  : Receives one DATA_WIDTH-bit word from SDA, one bit per SCL high
//            phase, and flags START/STOP conditions seen mid-word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_read_word
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            read_en,
  input  logic                            scl_i,
  input  logic                            sda_i,
  output logic [DATA_WIDTH-1:0]           read_data_o,
  output logic                            read_finish,
  output logic                            read_err,
  output logic                            read_err_type,
  output logic [$clog2(DATA_WIDTH+1)-1:0] read_err_bit,
  output logic                            busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ref;
  logic                  r_err_type;
  logic [CW-1:0]         r_err_bit;
  logic                  w_last;

  assign w_last = (r_cnt == C_LAST);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[DATA_WIDTH-2:0], sda_i};
    end else begin : g_lsb_first
      assign w_shift_next = {sda_i, r_shift[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_ref      <= 1'b0;
      r_err_type <= ERR_START;
      r_err_bit  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (read_en) r_cnt <= '0;
        end
        S_WAIT_HIGH: begin
          if (scl_i) begin
            r_ref   <= sda_i;
            r_shift <= w_shift_next;
          end
        end
        S_HIGH: begin
          // A falling SCL wins over an SDA change seen in the same cycle.
          if (!scl_i) begin
            if (w_last) r_data <= r_shift;
            else        r_cnt  <= r_cnt + CW'(1);
          end else if (sda_i != r_ref) begin
            r_err_type <= sda_i ? ERR_STOP : ERR_START;
            r_err_bit  <= r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (read_en) w_state_next = S_WAIT_HIGH;
      S_WAIT_HIGH: if (scl_i)   w_state_next = S_HIGH;
      S_HIGH: begin
        if (!scl_i)              w_state_next = w_last ? S_DONE : S_WAIT_HIGH;
        else if (sda_i != r_ref) w_state_next = S_ERR;
      end
      S_DONE:      w_state_next = S_IDLE;
      S_ERR:       w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  assign read_data_o   = r_data;
  assign read_finish   = (r_state == S_DONE);
  assign read_err      = (r_state == S_ERR);
  assign read_err_type = r_err_type;
  assign read_err_bit  = r_err_bit;
  assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_read_word.sv
// ============================================================================
// Module   : tb_i2c_slave_read_word
// Purpose  : Directed self-checking bench for i2c_slave_read_word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_read_word;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b0;
  logic sda = 1'b0;
  logic en8 = 1'b0;
  logic en16 = 1'b0;

  logic [7:0]  dat_a, dat_b;
  logic [15:0] dat_c;
  logic        fin_a, fin_b, fin_c, err_a, err_b, err_c;
  logic        typ_a, typ_b, typ_c, busy_a, busy_b, busy_c;
  logic [3:0]  ebit_a, ebit_b;
  logic [4:0]  ebit_c;

  always #5 clk = ~clk;

  i2c_slave_read_word #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .read_en(en8), .scl_i(scl), .sda_i(sda),
    .read_data_o(dat_a), .read_finish(fin_a), .read_err(err_a),
    .read_err_type(typ_a), .read_err_bit(ebit_a), .busy(busy_a));

  i2c_slave_read_word #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .read_en(en8), .scl_i(scl), .sda_i(sda),
    .read_data_o(dat_b), .read_finish(fin_b), .read_err(err_b),
    .read_err_type(typ_b), .read_err_bit(ebit_b), .busy(busy_b));

  i2c_slave_read_word #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .read_en(en16), .scl_i(scl), .sda_i(sda),
    .read_data_o(dat_c), .read_finish(fin_c), .read_err(err_c),
    .read_err_type(typ_c), .read_err_bit(ebit_c), .busy(busy_c));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling clock edge.
  int          nfin_a = 0, nfin_b = 0, nfin_c = 0, nerr_a = 0, nerr_b = 0;
  logic [7:0]  cap_a = '0, cap_b = '0;
  logic [15:0] cap_c = '0;
  logic        ctyp_a = 1'b0, ctyp_b = 1'b0;
  logic [3:0]  cbit_a = '0, cbit_b = '0;

  always @(negedge clk) begin
    if (fin_a) begin nfin_a++; cap_a = dat_a; end
    if (fin_b) begin nfin_b++; cap_b = dat_b; end
    if (fin_c) begin nfin_c++; cap_c = dat_c; end
    if (err_a) begin nerr_a++; ctyp_a = typ_a; cbit_a = ebit_a; end
    if (err_b) begin nerr_b++; ctyp_b = typ_b; cbit_b = ebit_b; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SCL period is 8 clk: 4 high, 4 low; read_en follows the first rise by 1 clk.
  task automatic send_word(input logic [31:0] w, input int nb, input bit use16,
                           input int glitch_bit, input int rst_bit, input int extra_bit);
    for (int i = 0; i < nb; i++) begin
      sda = w[nb-1-i];
      step(); scl = 1'b1;
      step();
      if (i == 0) begin
        if (use16) en16 = 1'b1;
        else       en8  = 1'b1;
      end
      if (i == extra_bit) begin
        check_val("busy_during_word", {31'd0, busy_a}, 32'd1);
        en8 = 1'b1;
      end
      step(); en8 = 1'b0; en16 = 1'b0;
      if (i == glitch_bit) sda = ~sda;
      step();
      step(); scl = 1'b0;
      step();
      step();
      step();
      if (i == rst_bit) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_data",   {24'd0, dat_a}, 32'd0);
        check_val("rst_finish", {31'd0, fin_a}, 32'd0);
        check_val("rst_err",    {31'd0, err_a}, 32'd0);
        check_val("rst_busy",   {31'd0, busy_a}, 32'd0);
        check_val("rst_type",   {31'd0, typ_a}, 32'd0);
        check_val("rst_bit",    {28'd0, ebit_a}, 32'd0);
        step();
        rst_n = 1'b1;
      end
    end
  endtask

  logic [7:0] words [4] = '{8'h13, 8'h57, 8'h9B, 8'hDF};
  logic [7:0] rev   [4] = '{8'hC8, 8'hEA, 8'hD9, 8'hFB};

  initial begin
    step(); step(); step();
    check_val("reset_data",   {24'd0, dat_a}, 32'd0);
    check_val("reset_finish", {31'd0, fin_a}, 32'd0);
    check_val("reset_err",    {31'd0, err_a}, 32'd0);
    check_val("reset_type",   {31'd0, typ_a}, 32'd0);
    check_val("reset_bit",    {28'd0, ebit_a}, 32'd0);
    check_val("reset_busy",   {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;
    step(); step();

    for (int k = 0; k < 4; k++) begin
      send_word({24'd0, words[k]}, 8, 1'b0, -1, -1, -1);
      check_val("msb_fin_count", nfin_a, k + 1);
      check_val("msb_data", {24'd0, cap_a}, {24'd0, words[k]});
      check_val("lsb_fin_count", nfin_b, k + 1);
      check_val("lsb_data", {24'd0, cap_b}, {24'd0, rev[k]});
    end
    check_val("no_err_a", nerr_a, 0);
    check_val("no_err_b", nerr_b, 0);

    send_word(32'h1357, 16, 1'b1, -1, -1, -1);
    check_val("w16_fin_count", nfin_c, 1);
    check_val("w16_data", {16'd0, cap_c}, 32'h1357);
    check_val("w16_other_idle", nfin_a, 4);

    send_word(32'h13, 8, 1'b0, 3, -1, -1);
    check_val("start_err_count", nerr_a, 1);
    check_val("start_err_type", {31'd0, ctyp_a}, 32'd0);
    check_val("start_err_bit", {28'd0, cbit_a}, 32'd3);
    check_val("start_err_bit_lsb", {28'd0, cbit_b}, 32'd3);
    check_val("start_no_finish", nfin_a, 4);
    check_val("start_data_kept", {24'd0, dat_a}, 32'hDF);

    send_word(32'hC8, 8, 1'b0, 3, -1, -1);
    check_val("stop_err_count", nerr_a, 2);
    check_val("stop_err_type", {31'd0, ctyp_a}, 32'd1);
    check_val("stop_err_type_lsb", {31'd0, ctyp_b}, 32'd1);
    check_val("stop_err_bit", {28'd0, cbit_a}, 32'd3);
    check_val("stop_no_finish", nfin_a, 4);

    send_word(32'h57, 8, 1'b0, -1, 5, -1);
    check_val("rst_no_finish", nfin_a, 4);
    check_val("rst_no_err", nerr_a, 2);
    send_word(32'h9B, 8, 1'b0, -1, -1, -1);
    check_val("post_rst_fin", nfin_a, 5);
    check_val("post_rst_data", {24'd0, cap_a}, 32'h9B);

    send_word(32'hA5, 8, 1'b0, -1, -1, 4);
    step(); step(); step(); step(); step(); step(); step(); step();
    check_val("busy_en_one_fin", nfin_a, 6);
    check_val("busy_en_data", {24'd0, cap_a}, 32'hA5);
    check_val("idle_busy", {31'd0, busy_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
